// File: rtl/thermo_expand32_if.sv
// Valid/ready bus for thermo_expand32: count in, thermometer mask out.
// chk_err exists only when THERMO_LOOPBACK_CHECK_EN is defined.
interface thermo_expand32_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mask;
  logic        out_ovf;
`ifdef THERMO_LOOPBACK_CHECK_EN
  logic        chk_err;

  modport master (output in_valid, in_count, out_ready,
                  input  in_ready, out_valid, out_mask, out_ovf, chk_err);
  modport slave  (input  in_valid, in_count, out_ready,
                  output in_ready, out_valid, out_mask, out_ovf, chk_err);
`else
  modport master (output in_valid, in_count, out_ready,
                  input  in_ready, out_valid, out_mask, out_ovf);
  modport slave  (input  in_valid, in_count, out_ready,
                  output in_ready, out_valid, out_mask, out_ovf);
`endif
endinterface

// File: rtl/thermo_expand32.sv
// 6-bit count to 32-bit thermometer mask, latency 2 + BUF_STAGES, stall-all pipeline.
// Optional loopback popcount checker enabled by THERMO_LOOPBACK_CHECK_EN.
module thermo_expand32 #(
  parameter int BUF_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  thermo_expand32_if.slave bus
);

  localparam int LAST = BUF_STAGES;

  // Byte-sliced decode: full bytes below sat[5:3], partial byte at sat[5:3].
  function automatic logic [31:0] thermo_decode(input logic [5:0] sat);
    logic [2:0]  hi;
    logic [7:0]  part;
    logic [31:0] m;
    hi   = sat[5:3];
    part = (8'd1 << sat[2:0]) - 8'd1;
    m    = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < hi) begin
        m[b*8 +: 8] = 8'hFF;
      end else if (3'(b) == hi) begin
        m[b*8 +: 8] = part;
      end else begin
        m[b*8 +: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  logic        stall_s;
  logic        in_ovf_s;
  logic [5:0]  in_sat_s;
  logic        s1_valid_r;
  logic [5:0]  s1_sat_r;
  logic        s1_ovf_r;
  logic        pipe_valid_r [0:LAST];
  logic [31:0] pipe_mask_r  [0:LAST];
  logic        pipe_ovf_r   [0:LAST];

  // Stall detection and input saturation.
  always_comb begin
    stall_s  = pipe_valid_r[LAST] & ~bus.out_ready;
    in_ovf_s = (bus.in_count > 6'd32);
    in_sat_s = in_ovf_s ? 6'd32 : bus.in_count;
  end

  assign bus.in_ready  = ~stall_s;
  assign bus.out_valid = pipe_valid_r[LAST];
  assign bus.out_mask  = pipe_mask_r[LAST];
  assign bus.out_ovf   = pipe_ovf_r[LAST];

  // Data is zeroed on load into an invalid slot, so out_mask reads 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sat_r   <= 6'd0;
      s1_ovf_r   <= 1'b0;
      for (int i = 0; i <= LAST; i++) begin
        pipe_valid_r[i] <= 1'b0;
        pipe_mask_r[i]  <= 32'd0;
        pipe_ovf_r[i]   <= 1'b0;
      end
    end else if (!stall_s) begin
      s1_valid_r      <= bus.in_valid;
      s1_sat_r        <= bus.in_valid ? in_sat_s : 6'd0;
      s1_ovf_r        <= bus.in_valid & in_ovf_s;
      pipe_valid_r[0] <= s1_valid_r;
      pipe_mask_r[0]  <= s1_valid_r ? thermo_decode(s1_sat_r) : 32'd0;
      pipe_ovf_r[0]   <= s1_valid_r & s1_ovf_r;
      for (int i = 1; i <= LAST; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_mask_r[i]  <= pipe_mask_r[i-1];
        pipe_ovf_r[i]   <= pipe_ovf_r[i-1];
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

`ifdef THERMO_LOOPBACK_CHECK_EN
  function automatic logic [5:0] popcount32(input logic [31:0] m);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, m[i]};
    end
    return cnt;
  endfunction

  logic [5:0] pipe_sat_r [0:LAST];
  logic       chk_err_r;

  assign bus.chk_err = chk_err_r;

  // Carries sat beside the mask so the output can be re-counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LAST; i++) begin
        pipe_sat_r[i] <= 6'd0;
      end
    end else if (!stall_s) begin
      pipe_sat_r[0] <= s1_sat_r;
      for (int i = 1; i <= LAST; i++) begin
        pipe_sat_r[i] <= pipe_sat_r[i-1];
      end
    end else begin
      pipe_sat_r[0] <= pipe_sat_r[0];
    end
  end

  // Sticky error on any delivered mask whose popcount disagrees with sat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_r <= 1'b0;
    end else if (bus.out_valid && bus.out_ready &&
                 (popcount32(bus.out_mask) != pipe_sat_r[LAST])) begin
      chk_err_r <= 1'b1;
    end else begin
      chk_err_r <= chk_err_r;
    end
  end
`endif

endmodule
